// File: rtl/rgb565_word_pack.sv
// -----------------------------------------------------------------------------
// rgb565_word_pack
//
// Purpose:
//   Packs a stream of RGB565 pixels, two per word, into 32-bit words for the
//   frame-buffer write path. A two-state packer (EMPTY / HALF) pairs pixels.
//   A 2-entry output FIFO absorbs downstream back-pressure. The block also
//   realigns on start-of-frame and counts the words handed off in each frame.
//
// Parameters:
//   FIRST_LOW : 1 -> earlier pixel in [15:0]; 0 -> earlier pixel in [31:16]
//   CNT_W     : width of the per-frame word counter
//
// Optional feature (compile-time macro):
//   PACK_LINE_FLUSH_EN : when defined, an end-of-line pixel that arrives with
//                        the packer EMPTY is flushed at once as a half word.
//                        The other half of that word is zero, so every line
//                        starts word-aligned. When the macro is undefined,
//                        i_pix_eol is ignored.
//
// Ports:
//   i_clk, i_rst_n            : clock, asynchronous active-low reset
//   i_pix_valid / o_pix_ready : input pixel handshake
//   i_pix_sof, i_pix_eol      : first pixel of frame / last pixel of line
//   i_rgbdata_r/g/b           : 5/6/5-bit colour components
//   o_word_valid/i_word_ready : output word handshake
//   o_word_data, o_word_sof   : head word of the output FIFO and its sof flag
//   o_word_cnt                : words handed off in the current frame
// -----------------------------------------------------------------------------
module rgb565_word_pack #(
    parameter int FIRST_LOW = 1,
    parameter int CNT_W     = 20
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_pix_valid,
    output logic             o_pix_ready,
    input  logic             i_pix_sof,
    input  logic             i_pix_eol,
    input  logic [4:0]       i_rgbdata_r,
    input  logic [5:0]       i_rgbdata_g,
    input  logic [4:0]       i_rgbdata_b,
    output logic             o_word_valid,
    input  logic             i_word_ready,
    output logic [31:0]      o_word_data,
    output logic             o_word_sof,
    output logic [CNT_W-1:0] o_word_cnt
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_HALF  = 1'b1
    } state_t;

    state_t            state_q;
    state_t            state_d;

    logic [15:0]       pix;
    logic              pix_xfer;
    logic              word_xfer;
    logic              flush_eol;

    logic [15:0]       hold_q;
    logic              hold_sof_q;
    logic              hold_load;

    logic              push;
    logic [31:0]       push_data;
    logic              push_sof;

    // Output FIFO: two entries addressed by 1-bit pointers
    logic [1:0][31:0]  buf_data_q;
    logic [1:0]        buf_sof_q;
    logic              wr_ptr_q;
    logic              rd_ptr_q;
    logic [1:0]        occ_q;

    logic [CNT_W-1:0]  cnt_q;

    // Place the earlier / later pixel according to FIRST_LOW
    function automatic logic [31:0] pair(input logic [15:0] early,
                                         input logic [15:0] late);
        if (FIRST_LOW != 0) begin
            return {late, early};
        end
        return {early, late};
    endfunction

    assign pix = {i_rgbdata_r, i_rgbdata_g, i_rgbdata_b};

    // Ready depends only on registered occupancy. This keeps the input
    // side free of a combinational path from i_word_ready.
    assign o_pix_ready  = (occ_q != 2'd2);
    assign o_word_valid = (occ_q != 2'd0);
    assign o_word_data  = buf_data_q[rd_ptr_q];
    assign o_word_sof   = buf_sof_q[rd_ptr_q];
    assign o_word_cnt   = cnt_q;

    assign pix_xfer  = i_pix_valid && o_pix_ready;
    assign word_xfer = o_word_valid && i_word_ready;

`ifdef PACK_LINE_FLUSH_EN
    assign flush_eol = i_pix_eol;
`else
    logic unused_eol;
    assign flush_eol  = 1'b0;
    assign unused_eol = i_pix_eol;
`endif

    // ---------------------------------------------------------------- FSM
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_EMPTY: begin
                // A flushed eol pixel is emitted directly, so the packer stays EMPTY
                if (pix_xfer && !flush_eol) begin
                    state_d = S_HALF;
                end
            end
            S_HALF: begin
                // A sof pixel replaces the held pixel and restarts the pair
                if (pix_xfer && !i_pix_sof) begin
                    state_d = S_EMPTY;
                end
            end
            default: state_d = S_EMPTY;
        endcase
    end

    always_comb begin
        hold_load = 1'b0;
        push      = 1'b0;
        push_data = '0;
        push_sof  = 1'b0;
        case (state_q)
            S_EMPTY: begin
                if (pix_xfer) begin
                    if (flush_eol) begin
                        push      = 1'b1;
                        push_data = pair(pix, 16'h0000);
                        push_sof  = i_pix_sof;
                    end else begin
                        hold_load = 1'b1;
                    end
                end
            end
            S_HALF: begin
                if (pix_xfer) begin
                    if (i_pix_sof) begin
                        // The held half-word is dropped without output
                        hold_load = 1'b1;
                    end else begin
                        push      = 1'b1;
                        push_data = pair(hold_q, pix);
                        push_sof  = hold_sof_q;
                    end
                end
            end
            default: ;
        endcase
    end

    // ---------------------------------------------------------- hold register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold_q     <= '0;
            hold_sof_q <= 1'b0;
        end else if (hold_load) begin
            hold_q     <= pix;
            hold_sof_q <= i_pix_sof;
        end
    end

    // ------------------------------------------------------------ output FIFO
    // Push cannot coincide with a full FIFO, because ready is low at occupancy 2.
    // A simultaneous push and pop therefore never overwrites the head entry.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            buf_data_q <= '0;
            buf_sof_q  <= '0;
            wr_ptr_q   <= 1'b0;
            rd_ptr_q   <= 1'b0;
            occ_q      <= 2'd0;
        end else begin
            if (push) begin
                buf_data_q[wr_ptr_q] <= push_data;
                buf_sof_q[wr_ptr_q]  <= push_sof;
                wr_ptr_q             <= ~wr_ptr_q;
            end
            if (word_xfer) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
            case ({push, word_xfer})
                2'b10:   occ_q <= occ_q + 2'd1;
                2'b01:   occ_q <= occ_q - 2'd1;
                default: occ_q <= occ_q;
            endcase
        end
    end

    // ------------------------------------------------------- frame word count
    // A sof word starts a new frame, so it counts as word 1 rather than adding to the old count
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q <= '0;
        end else if (word_xfer) begin
            if (o_word_sof) begin
                cnt_q <= CNT_W'(1);
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_rgb565_word_pack.sv
module tb_rgb565_word_pack;

    logic        clk;
    logic        rst_n;
    logic        pv, psof, peol, wr;
    logic [4:0]  r, b;
    logic [5:0]  g;
    logic        ready0, ready1, valid0, valid1, wsof0, wsof1;
    logic [31:0] data0, data1;
    logic [19:0] cnt0;
    logic [3:0]  cnt1;

    int n_checks = 0;
    int n_errors = 0;

`ifdef PACK_LINE_FLUSH_EN
    localparam bit FLUSH = 1'b1;
`else
    localparam bit FLUSH = 1'b0;
`endif

    // Two instances receive identical stimulus. They differ in pixel order and in counter width.
    rgb565_word_pack #(.FIRST_LOW(1), .CNT_W(20)) dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_valid(pv), .o_pix_ready(ready0),
        .i_pix_sof(psof), .i_pix_eol(peol), .i_rgbdata_r(r), .i_rgbdata_g(g),
        .i_rgbdata_b(b), .o_word_valid(valid0), .i_word_ready(wr),
        .o_word_data(data0), .o_word_sof(wsof0), .o_word_cnt(cnt0));

    rgb565_word_pack #(.FIRST_LOW(0), .CNT_W(4)) dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_pix_valid(pv), .o_pix_ready(ready1),
        .i_pix_sof(psof), .i_pix_eol(peol), .i_rgbdata_r(r), .i_rgbdata_g(g),
        .i_rgbdata_b(b), .o_word_valid(valid1), .i_word_ready(wr),
        .o_word_data(data1), .o_word_sof(wsof1), .o_word_cnt(cnt1));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a queue of words waiting downstream plus one pending pixel
    typedef struct {
        logic        sof;
        logic [15:0] early;
        logic [15:0] late;
    } word_t;

    word_t       mq[$];
    bit          m_half;
    logic [15:0] m_hold;
    logic        m_hsof;
    logic [31:0] m_cnt;

    function automatic void model_clear();
        mq.delete();
        m_half = 0;
        m_hold = '0;
        m_hsof = 0;
        m_cnt  = 0;
    endfunction

    function automatic void model_accept(input logic s, input logic e, input logic [15:0] p);
        if (!m_half) begin
            if (FLUSH && e) mq.push_back('{sof: s, early: p, late: 16'h0000});
            else begin m_half = 1; m_hold = p; m_hsof = s; end
        end else if (s) begin
            m_hold = p; m_hsof = 1'b1;
        end else begin
            mq.push_back('{sof: m_hsof, early: m_hold, late: p});
            m_half = 0;
        end
    endfunction

    // Drive one cycle of stimulus, then advance the model across the clock edge.
    // The task returns at posedge+1, where the DUT outputs are ready to sample.
    task automatic step(input logic v, input logic s, input logic e,
                        input logic [15:0] p, input logic w, output logic acc);
        word_t wd;
        pv = v; psof = s; peol = e; wr = w;
        r = p[15:11]; g = p[10:5]; b = p[4:0];
        acc = v && (mq.size() != 2);
        @(posedge clk);
        if (w && mq.size() != 0) begin
            wd = mq.pop_front();
            m_cnt = wd.sof ? 32'd1 : m_cnt + 32'd1;
        end
        if (acc) model_accept(s, e, p);
        #1;
    endtask

    task automatic do_reset();
        pv = 0; psof = 0; peol = 0; wr = 0; r = 0; g = 0; b = 0;
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_clear();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (valid0 !== 1'b0) begin n_errors++; $display("FAIL reset_valid: got %b want 0", valid0); end
        n_checks++; if (data0 !== 32'h0) begin n_errors++; $display("FAIL reset_data: got %h want 0", data0); end
        n_checks++; if (wsof0 !== 1'b0) begin n_errors++; $display("FAIL reset_sof: got %b want 0", wsof0); end
        n_checks++; if (cnt0 !== 20'h0) begin n_errors++; $display("FAIL reset_cnt: got %h want 0", cnt0); end
        n_checks++; if (ready0 !== 1'b1 || ready1 !== 1'b1) begin n_errors++; $display("FAIL reset_ready: got %b%b want 11", ready0, ready1); end
    endtask

    task automatic test_basic();
        logic acc;
        step(1, 0, 0, 16'h1234, 1, acc);
        n_checks++; if (valid0 !== 1'b0) begin n_errors++; $display("FAIL basic_half_valid: got %b want 0", valid0); end
        step(1, 0, 0, 16'hABCD, 1, acc);
        n_checks++; if (valid0 !== 1'b1) begin n_errors++; $display("FAIL basic_valid: got %b want 1", valid0); end
        n_checks++; if (data0 !== 32'hABCD1234) begin n_errors++; $display("FAIL basic_data_low: got %h want abcd1234", data0); end
        n_checks++; if (data1 !== 32'h1234ABCD) begin n_errors++; $display("FAIL basic_data_high: got %h want 1234abcd", data1); end
        step(0, 0, 0, 16'h0, 1, acc);
        n_checks++; if (cnt0 !== 20'd1) begin n_errors++; $display("FAIL basic_cnt: got %0d want 1", cnt0); end
        n_checks++; if (valid0 !== 1'b0) begin n_errors++; $display("FAIL basic_drained: got %b want 0", valid0); end
    endtask

    task automatic test_back_pressure();
        logic [15:0] p[6];
        logic [31:0] got[3];
        logic acc;
        int idx = 0;
        int n = 0;
        for (int i = 0; i < 6; i++) p[i] = 16'($urandom);
        for (int c = 0; c < 6; c++) begin
            step(1, 0, 0, p[idx], 0, acc);
            if (acc) idx++;
            if (c >= 2) begin
                n_checks++; if (data0 !== {p[1], p[0]}) begin n_errors++; $display("FAIL bp_head_steady: got %h want %h", data0, {p[1], p[0]}); end
            end
        end
        n_checks++; if (idx !== 4) begin n_errors++; $display("FAIL bp_accepted: got %0d want 4", idx); end
        n_checks++; if (ready0 !== 1'b0) begin n_errors++; $display("FAIL bp_ready_low: got %b want 0", ready0); end
        for (int c = 0; c < 20 && n < 3; c++) begin
            if (valid0) begin got[n] = data0; n++; end
            step(idx < 6, 0, 0, p[idx < 6 ? idx : 0], 1, acc);
            if (acc) idx++;
        end
        n_checks++; if (n !== 3) begin n_errors++; $display("FAIL bp_drain_count: got %0d want 3", n); end
        for (int i = 0; i < 3; i++) begin
            n_checks++; if (got[i] !== {p[2*i+1], p[2*i]}) begin n_errors++; $display("FAIL bp_order[%0d]: got %h want %h", i, got[i], {p[2*i+1], p[2*i]}); end
        end
    endtask

    task automatic test_sof_realign();
        logic acc;
        step(1, 0, 0, 16'h0001, 1, acc);
        step(1, 1, 0, 16'h00AA, 1, acc);
        n_checks++; if (valid0 !== 1'b0) begin n_errors++; $display("FAIL sof_discard: got valid %b want 0", valid0); end
        step(1, 0, 0, 16'h00BB, 1, acc);
        n_checks++; if (data0 !== 32'h00BB00AA) begin n_errors++; $display("FAIL sof_data: got %h want 00bb00aa", data0); end
        n_checks++; if (data1 !== 32'h00AA00BB) begin n_errors++; $display("FAIL sof_data_high: got %h want 00aa00bb", data1); end
        n_checks++; if (wsof0 !== 1'b1) begin n_errors++; $display("FAIL sof_flag: got %b want 1", wsof0); end
        step(0, 0, 0, 16'h0, 1, acc);
        n_checks++; if (cnt0 !== 20'd1) begin n_errors++; $display("FAIL sof_cnt: got %0d want 1", cnt0); end
        n_checks++; if (valid0 !== 1'b0) begin n_errors++; $display("FAIL sof_single_word: got valid %b want 0", valid0); end
    endtask

    task automatic test_line_flush();
        logic [15:0] p[5];
        logic [31:0] got[4];
        logic [31:0] exp_w[3];
        logic acc;
        int idx = 0;
        int n = 0;
        int n_exp;
        for (int i = 0; i < 5; i++) p[i] = 16'($urandom) | 16'h0001;
        for (int c = 0; c < 12; c++) begin
            if (valid0 && n < 4) begin got[n] = data0; n++; end
            step(idx < 5, 0, idx == 2, p[idx < 5 ? idx : 0], 1, acc);
            if (acc) idx++;
        end
        if (FLUSH) begin
            n_exp = 3;
            exp_w[0] = {p[1], p[0]}; exp_w[1] = {16'h0000, p[2]}; exp_w[2] = {p[4], p[3]};
        end else begin
            n_exp = 2;
            exp_w[0] = {p[1], p[0]}; exp_w[1] = {p[3], p[2]}; exp_w[2] = '0;
        end
        n_checks++; if (n !== n_exp) begin n_errors++; $display("FAIL flush_count: got %0d want %0d", n, n_exp); end
        for (int i = 0; i < n_exp && i < n; i++) begin
            n_checks++; if (got[i] !== exp_w[i]) begin n_errors++; $display("FAIL flush_word[%0d]: got %h want %h", i, got[i], exp_w[i]); end
        end
    endtask

    task automatic test_reset_mid();
        logic [15:0] q0, q1;
        logic acc;
        for (int i = 0; i < 4; i++) step(1, 0, 0, 16'($urandom), 0, acc);
        step(1, 0, 0, 16'h5555, 1, acc);
        step(1, 0, 0, 16'h5555, 0, acc);
        n_checks++; if (valid0 !== 1'b1 || cnt0 === 20'd0) begin n_errors++; $display("FAIL mid_precond: got valid %b cnt %0d want 1/nonzero", valid0, cnt0); end
        rst_n = 1'b0;
        #2;
        n_checks++; if (valid0 !== 1'b0 || ready0 !== 1'b1) begin n_errors++; $display("FAIL mid_async_hs: got valid %b ready %b want 0/1", valid0, ready0); end
        n_checks++; if (data0 !== 32'h0 || wsof0 !== 1'b0) begin n_errors++; $display("FAIL mid_async_data: got %h/%b want 0/0", data0, wsof0); end
        n_checks++; if (cnt0 !== 20'd0) begin n_errors++; $display("FAIL mid_async_cnt: got %0d want 0", cnt0); end
        @(posedge clk);
        #1 rst_n = 1'b1;
        model_clear();
        q0 = 16'($urandom); q1 = 16'($urandom);
        step(1, 0, 0, q0, 1, acc);
        step(1, 0, 0, q1, 1, acc);
        n_checks++; if (valid0 !== 1'b1 || data0 !== {q1, q0}) begin n_errors++; $display("FAIL mid_fresh_word: got %b/%h want 1/%h", valid0, data0, {q1, q0}); end
        step(0, 0, 0, 16'h0, 1, acc);
    endtask

    task automatic test_random_stream();
        logic acc;
        word_t hw;
        for (int c = 0; c < 800; c++) begin
            n_checks++; if (valid0 !== (mq.size() != 0) || valid1 !== valid0) begin n_errors++; $display("FAIL rnd_valid c%0d: got %b%b want %b", c, valid0, valid1, mq.size() != 0); end
            n_checks++; if (ready0 !== (mq.size() != 2) || ready1 !== ready0) begin n_errors++; $display("FAIL rnd_ready c%0d: got %b%b want %b", c, ready0, ready1, mq.size() != 2); end
            n_checks++; if (cnt0 !== m_cnt[19:0] || cnt1 !== m_cnt[3:0]) begin n_errors++; $display("FAIL rnd_cnt c%0d: got %0d/%0d want %0d", c, cnt0, cnt1, m_cnt[19:0]); end
            if (mq.size() != 0) begin
                hw = mq[0];
                n_checks++; if (data0 !== {hw.late, hw.early} || data1 !== {hw.early, hw.late}) begin n_errors++; $display("FAIL rnd_data c%0d: got %h/%h want %h", c, data0, data1, {hw.late, hw.early}); end
                n_checks++; if (wsof0 !== hw.sof || wsof1 !== hw.sof) begin n_errors++; $display("FAIL rnd_sof c%0d: got %b%b want %b", c, wsof0, wsof1, hw.sof); end
            end
            step($urandom_range(3, 0) != 0, $urandom_range(15, 0) == 0, $urandom_range(7, 0) == 0,
                 16'($urandom), $urandom_range(1, 0) == 1, acc);
        end
    endtask

    task automatic test_cnt_wrap();
        logic acc;
        int pops = 0;
        do_reset();
        for (int c = 0; c < 200 && pops < 17; c++) begin
            if (valid0) pops++;
            step(1, 0, 0, 16'($urandom), 1, acc);
        end
        n_checks++; if (pops !== 17) begin n_errors++; $display("FAIL wrap_timeout: got %0d words want 17", pops); end
        n_checks++; if (cnt1 !== 4'd1) begin n_errors++; $display("FAIL wrap_cnt4: got %0d want 1", cnt1); end
        n_checks++; if (cnt0 !== 20'd17) begin n_errors++; $display("FAIL wrap_cnt20: got %0d want 17", cnt0); end
    endtask

    initial begin
        rst_n = 1'b1;
        model_clear();
        test_reset();
        test_basic();
        test_back_pressure();
        test_sof_realign();
        test_line_flush();
        test_reset_mid();
        test_random_stream();
        test_cnt_wrap();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
